// File: rtl/store_merge_if.sv
// Handshake and data-memory signals between the control unit, the store merge unit and memory.
// The slave modport is the merge unit; the master side is the control unit together with memory.
interface store_merge_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  start, op, addr, store_data, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, busy, done, err
  );

  modport master (
    output start, op, addr, store_data, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, busy, done, err
  );
endinterface

// File: rtl/store_merge_unit.sv
// Store path for SW/SH/SB: SW writes the word directly; SH/SB read the target word,
// splice the low halfword/byte of the B register into it and write it back.
module store_merge_unit #(
  parameter int MEM_LATENCY = 1
) (
  input logic          clk,
  input logic          reset,
  store_merge_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_SW  = 2'b00;
  localparam logic [1:0] OP_SH  = 2'b01;
  localparam logic [1:0] OP_ILL = 2'b11;
  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_op;
  logic [31:0] r_data;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [2:0]  r_cnt;
  logic        w_accept;

  // SH keeps the upper halfword, SB the upper three bytes; lanes never depend on addr.
  function automatic logic [31:0] merge_word(input logic [1:0] op,
                                             input logic [31:0] rdata,
                                             input logic [31:0] sdata);
    if (op == OP_SH) merge_word = {rdata[31:16], sdata[15:0]};
    else             merge_word = {rdata[31:8],  sdata[7:0]};
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_SW)       w_next = S_WRITE;
          else if (bus.op == OP_ILL) w_next = S_DONE;
          else                       w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 3'd0) w_next = S_WRITE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Address/data registers only move on acceptance or at the end of the read wait,
  // so they hold their last values through IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op        <= 2'b00;
      r_data      <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_cnt       <= 3'd0;
    end else begin
      if (w_accept) begin
        r_op   <= bus.op;
        r_data <= bus.store_data;
        if (bus.op != OP_ILL) r_mem_addr  <= bus.addr;
        if (bus.op == OP_SW)  r_mem_wdata <= bus.store_data;
      end
      if (r_state == S_READ) r_cnt <= CNT_INIT;
      if (r_state == S_WAIT) begin
        if (r_cnt != 3'd0) r_cnt       <= r_cnt - 3'd1;
        else               r_mem_wdata <= merge_word(r_op, bus.mem_rdata, r_data);
      end
    end
  end

  // Strobes decode straight from the state register so an async reset kills a write at once.
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wr    = (r_state == S_WRITE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = (r_state == S_DONE) && (r_op == OP_ILL);

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit with two instances (MEM_LATENCY 1 and 3) and
// small delayed-read memory models that return the test word only for a matured read address.
module tb_store_merge_unit;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  store_merge_if if1 ();
  store_merge_if if3 ();

  store_merge_unit #(.MEM_LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  store_merge_unit #(.MEM_LATENCY(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] tgt1, word1, d1;
  logic        d1_rd;
  logic [31:0] tgt3, word3;
  logic [31:0] d3 [3];
  logic        d3_rd [3];

  always @(posedge clk) begin
    d1    <= if1.mem_addr;
    d1_rd <= !if1.mem_wr;
    d3[0] <= if3.mem_addr;  d3_rd[0] <= !if3.mem_wr;
    d3[1] <= d3[0];         d3_rd[1] <= d3_rd[0];
    d3[2] <= d3[1];         d3_rd[2] <= d3_rd[1];
  end

  assign if1.mem_rdata = (d1_rd === 1'b1 && d1 === tgt1) ? word1 : 32'hBAD0_BAD0;
  assign if3.mem_rdata = (d3_rd[2] === 1'b1 && d3[2] === tgt3) ? word3 : 32'hBAD0_BAD0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    if1.start = 1'($urandom); if1.op = 2'($urandom); if1.addr = $urandom; if1.store_data = $urandom;
    if3.start = 1'($urandom); if3.op = 2'($urandom); if3.addr = $urandom; if3.store_data = $urandom;
    #3;
    n_vec++;
    if ({if1.mem_addr, if1.mem_wdata, if1.mem_wr, if1.busy, if1.done, if1.err} !== 68'd0) begin
      n_err++;
      $display("FAIL reset_outs_lat1: got addr=%h wdata=%h wr=%b busy=%b done=%b err=%b, want all 0",
               if1.mem_addr, if1.mem_wdata, if1.mem_wr, if1.busy, if1.done, if1.err);
    end
    n_vec++;
    if ({if3.mem_addr, if3.mem_wdata, if3.mem_wr, if3.busy, if3.done, if3.err} !== 68'd0) begin
      n_err++;
      $display("FAIL reset_outs_lat3: got addr=%h wdata=%h wr=%b busy=%b done=%b err=%b, want all 0",
               if3.mem_addr, if3.mem_wdata, if3.mem_wr, if3.busy, if3.done, if3.err);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    if1.start = 1'b0;
    if3.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      n_vec++;
      if ({if1.busy, if1.mem_wr, if3.busy, if3.mem_wr} !== 4'b0000) begin
        n_err++;
        $display("FAIL idle_after_reset cyc%0d: got busy1/wr1/busy3/wr3=%b, want 0000",
                 k, {if1.busy, if1.mem_wr, if3.busy, if3.mem_wr});
      end
    end
  endtask

  task automatic test_sw;
    if1.start = 1'b1; if1.op = 2'b00; if1.addr = 32'h0000_0010; if1.store_data = 32'hDEAD_BEEF;
    tick;
    if1.start = 1'b0; if1.addr = 32'h0000_0999; if1.store_data = 32'h0123_4567;
    n_vec++;
    if ({if1.mem_wr, if1.busy, if1.done} !== 3'b110 || if1.mem_addr !== 32'h10 ||
        if1.mem_wdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL sw_write: got wr/busy/done=%b addr=%h wdata=%h, want 110 addr=00000010 wdata=deadbeef",
               {if1.mem_wr, if1.busy, if1.done}, if1.mem_addr, if1.mem_wdata);
    end
    tick;
    n_vec++;
    if ({if1.mem_wr, if1.done, if1.err} !== 3'b010) begin
      n_err++;
      $display("FAIL sw_done: got wr/done/err=%b, want 010", {if1.mem_wr, if1.done, if1.err});
    end
    tick;
    n_vec++;
    if ({if1.busy, if1.done} !== 2'b00 || if1.mem_addr !== 32'h10 || if1.mem_wdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL sw_idle_hold: got busy/done=%b addr=%h wdata=%h, want 00 addr=00000010 wdata=deadbeef",
               {if1.busy, if1.done}, if1.mem_addr, if1.mem_wdata);
    end
  endtask

  task automatic test_sh_lat1;
    tgt1 = 32'h0000_0020; word1 = 32'h1122_3344;
    if1.start = 1'b1; if1.op = 2'b01; if1.addr = 32'h0000_0020; if1.store_data = 32'hAAAA_5566;
    tick;
    if1.start = 1'b0; if1.addr = 32'h0; if1.store_data = 32'h0;
    n_vec++;
    if (if1.mem_wr !== 1'b0 || if1.busy !== 1'b1 || if1.mem_addr !== 32'h20) begin
      n_err++;
      $display("FAIL sh_read: got wr=%b busy=%b addr=%h, want wr=0 busy=1 addr=00000020",
               if1.mem_wr, if1.busy, if1.mem_addr);
    end
    tick;
    n_vec++;
    if (if1.mem_wr !== 1'b0 || if1.done !== 1'b0) begin
      n_err++;
      $display("FAIL sh_wait: got wr=%b done=%b, want 0 0", if1.mem_wr, if1.done);
    end
    tick;
    n_vec++;
    if (if1.mem_wr !== 1'b1 || if1.mem_wdata !== 32'h1122_5566 || if1.mem_addr !== 32'h20) begin
      n_err++;
      $display("FAIL sh_write: got wr=%b wdata=%h addr=%h, want wr=1 wdata=11225566 addr=00000020",
               if1.mem_wr, if1.mem_wdata, if1.mem_addr);
    end
    tick;
    n_vec++;
    if ({if1.done, if1.err, if1.mem_wr} !== 3'b100) begin
      n_err++;
      $display("FAIL sh_done: got done/err/wr=%b, want 100", {if1.done, if1.err, if1.mem_wr});
    end
    tick;
    n_vec++;
    if (if1.busy !== 1'b0) begin
      n_err++;
      $display("FAIL sh_idle: got busy=%b, want 0", if1.busy);
    end
  endtask

  task automatic test_sb_lat3;
    tgt3 = 32'h0000_0040; word3 = 32'h1122_3344;
    if3.start = 1'b1; if3.op = 2'b10; if3.addr = 32'h0000_0040; if3.store_data = 32'hFFFF_FF99;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (k == 1) if3.start = 1'b0;
      if (k == 2) if3.store_data = 32'h1234_5600;
      if (k == 3) begin if3.op = 2'b01; if3.addr = 32'h0000_0077; end
      n_vec++;
      if ({if3.mem_wr, if3.done, if3.busy} !== {k == 5, k == 6, 1'b1}) begin
        n_err++;
        $display("FAIL sb_seq cyc%0d: got wr/done/busy=%b, want %b",
                 k, {if3.mem_wr, if3.done, if3.busy}, {k == 5, k == 6, 1'b1});
      end
      if (k == 5) begin
        n_vec++;
        if (if3.mem_wdata !== 32'h1122_3399 || if3.mem_addr !== 32'h40) begin
          n_err++;
          $display("FAIL sb_write: got wdata=%h addr=%h, want 11223399 00000040",
                   if3.mem_wdata, if3.mem_addr);
        end
      end
    end
    tick;
    n_vec++;
    if (if3.busy !== 1'b0) begin
      n_err++;
      $display("FAIL sb_idle: got busy=%b, want 0", if3.busy);
    end
  endtask

  task automatic test_illegal;
    if1.start = 1'b1; if1.op = 2'b11; if1.addr = 32'h0000_0099; if1.store_data = 32'h5A5A_5A5A;
    tick;
    if1.start = 1'b0;
    n_vec++;
    if ({if1.done, if1.err, if1.mem_wr, if1.busy} !== 4'b1101) begin
      n_err++;
      $display("FAIL illegal_done: got done/err/wr/busy=%b, want 1101",
               {if1.done, if1.err, if1.mem_wr, if1.busy});
    end
    tick;
    n_vec++;
    if ({if1.done, if1.err, if1.mem_wr, if1.busy} !== 4'b0000) begin
      n_err++;
      $display("FAIL illegal_after: got done/err/wr/busy=%b, want 0000",
               {if1.done, if1.err, if1.mem_wr, if1.busy});
    end
  endtask

  task automatic test_busy_ignore;
    int writes;
    writes = 0;
    tgt1 = 32'h0000_0020; word1 = 32'h1122_3344;
    if1.start = 1'b1; if1.op = 2'b01; if1.addr = 32'h0000_0020; if1.store_data = 32'h0000_7777;
    for (int k = 1; k <= 8; k++) begin
      tick;
      if (k == 1) begin if1.op = 2'b00; if1.addr = 32'h0000_0050; if1.store_data = 32'h5555_5555; end
      if (k == 5) if1.start = 1'b0;
      if (if1.mem_wr === 1'b1) begin
        writes++;
        n_vec++;
        if (if1.mem_wdata !== 32'h1122_7777 || if1.mem_addr !== 32'h20) begin
          n_err++;
          $display("FAIL busy_write cyc%0d: got wdata=%h addr=%h, want 11227777 00000020",
                   k, if1.mem_wdata, if1.mem_addr);
        end
      end
      if (k == 4) begin
        n_vec++;
        if (if1.done !== 1'b1) begin
          n_err++;
          $display("FAIL busy_done: got done=%b, want 1", if1.done);
        end
      end
    end
    n_vec++;
    if (writes != 1 || if1.busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_single_write: got writes=%0d busy=%b, want 1 0", writes, if1.busy);
    end
  endtask

  task automatic test_back_to_back;
    if1.start = 1'b1; if1.op = 2'b00; if1.addr = 32'h0000_0100; if1.store_data = 32'h0A0A_0A0A;
    tick;
    n_vec++;
    if (if1.mem_wr !== 1'b1 || if1.mem_addr !== 32'h100 || if1.mem_wdata !== 32'h0A0A_0A0A) begin
      n_err++;
      $display("FAIL b2b_first: got wr=%b addr=%h wdata=%h, want 1 00000100 0a0a0a0a",
               if1.mem_wr, if1.mem_addr, if1.mem_wdata);
    end
    if1.addr = 32'h0000_0104; if1.store_data = 32'h0B0B_0B0B;
    tick;
    n_vec++;
    if (if1.done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done1: got done=%b, want 1", if1.done);
    end
    tick;
    n_vec++;
    if ({if1.busy, if1.mem_wr} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_gap: got busy/wr=%b, want 00", {if1.busy, if1.mem_wr});
    end
    tick;
    if1.start = 1'b0;
    n_vec++;
    if (if1.mem_wr !== 1'b1 || if1.mem_addr !== 32'h104 || if1.mem_wdata !== 32'h0B0B_0B0B) begin
      n_err++;
      $display("FAIL b2b_second: got wr=%b addr=%h wdata=%h, want 1 00000104 0b0b0b0b",
               if1.mem_wr, if1.mem_addr, if1.mem_wdata);
    end
    tick;
    n_vec++;
    if (if1.done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done2: got done=%b, want 1", if1.done);
    end
    tick;
  endtask

  task automatic test_reset_mid_op;
    tgt3 = 32'h0000_0040; word3 = 32'h1122_3344;
    if3.start = 1'b1; if3.op = 2'b10; if3.addr = 32'h0000_0040; if3.store_data = 32'h0000_00AB;
    for (int k = 1; k <= 5; k++) begin
      tick;
      if (k == 1) if3.start = 1'b0;
    end
    n_vec++;
    if (if3.mem_wr !== 1'b1 || if3.mem_wdata !== 32'h1122_33AB) begin
      n_err++;
      $display("FAIL rst_mid_prewrite: got wr=%b wdata=%h, want 1 112233ab", if3.mem_wr, if3.mem_wdata);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({if3.mem_wr, if3.busy, if3.done} !== 3'b000 || if3.mem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid_async: got wr/busy/done=%b addr=%h, want 000 00000000",
               {if3.mem_wr, if3.busy, if3.done}, if3.mem_addr);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    if3.start = 1'b1; if3.op = 2'b00; if3.addr = 32'h0000_0060; if3.store_data = 32'hCAFE_F00D;
    tick;
    if3.start = 1'b0;
    n_vec++;
    if (if3.mem_wr !== 1'b1 || if3.mem_addr !== 32'h60 || if3.mem_wdata !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL rst_mid_sw_write: got wr=%b addr=%h wdata=%h, want 1 00000060 cafef00d",
               if3.mem_wr, if3.mem_addr, if3.mem_wdata);
    end
    tick;
    n_vec++;
    if ({if3.done, if3.err} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_mid_sw_done: got done/err=%b, want 10", {if3.done, if3.err});
    end
    tick;
    n_vec++;
    if (if3.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_sw_idle: got busy=%b, want 0", if3.busy);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    tgt1 = 32'hFFFF_FFFF; word1 = 32'h0;
    tgt3 = 32'hFFFF_FFFF; word3 = 32'h0;
    test_reset;
    test_sw;
    test_sh_lat1;
    test_sb_lat3;
    test_illegal;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid_op;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
